itch_msg_parser: RTL and testbench
==================================

# itch_msg_parser

Upstream stage of the order book engine. Consumes the byte stream of one MoldUDP64 UDP payload at a time and splits it into ITCH 5.0 messages. For Add ('A'/'F'), Order Delete ('D') and Order Executed ('E') messages, it extracts the fields and pulses the matching valid output. Those outputs drive the engine's add/delete/exec valid, ref number, locate, price, shares and buy/sell inputs directly; all other message types are skipped.

## Interface

Parameters:
- HDR_BYTES, default 20: MoldUDP64 header bytes skipped at packet start (session 10, sequence 8, count 2).

Ports:
- clkIn  input  1  single clock
- rstIn  input  1  reset, asynchronous, active-high
- dataInValid  input  1  byte qualifier; gaps allowed, no backpressure
- dataIn  input  8  payload byte, network order
- lastIn  input  1  qualifies the last byte of the UDP payload; valid only with dataInValid
- addValidOut  output  1  one-cycle pulse, Add ('A' or 'F') complete
- delValidOut  output  1  one-cycle pulse, Delete complete
- execValidOut  output  1  one-cycle pulse, Executed complete
- refNumOut  output  64  order reference number
- locateOut  output  16  stock locate
- priceOut  output  32  price; Add only, otherwise holds last value
- sharesOut  output  32  shares (Add) or executed shares (Exec)
- buySellOut  output  1  1 = 'B' (0x42), 0 otherwise; Add only
- errCntOut  output  16  saturating count of truncated or short messages

## Operation

- States:
  - HDR: count HDR_BYTES bytes, then go to LEN_HI.
  - LEN_HI, LEN_LO: latch 16-bit big-endian message length L. L excludes the length bytes.
  - BODY: byte offset counter 0..L-1.
  - Transitions: LEN_LO goes to BODY if L≠0, else to LEN_HI. BODY goes to LEN_HI after offset L-1.
- Offset 0 latches the type byte.
- Field capture by offset (big-endian shift-in):
  - locate: 1-2.
  - refNum: 11-18.
  - A/F only: buySell 19, shares 20-23, price 32-35.
  - E only: shares 19-22.
  - Tracking, timestamp, stock, match number and attribution are ignored.
- Minimum lengths: A 36, F 40, D 19, E 31.
  - Message of a supported type with L below its minimum: no pulse, errCnt +1.
  - L above the minimum: extra bytes are skipped, and the pulse fires at end of L.
- Unsupported types are skipped silently (no error).
- lastIn:
  - Any byte with lastIn returns to HDR after that byte is consumed.
  - lastIn on the final BODY byte of a supported, complete message: the message is emitted.
  - lastIn anywhere earlier in LEN/BODY: the partial message is discarded. errCnt +1 only if the type is supported and the byte arrived at offset ≥1.
- At most one of the three valid outputs is high in any cycle.
- errCntOut saturates at 0xFFFF.

## Timing

- Bytes are processed only on cycles with dataInValid=1. The state machine and counters hold otherwise.
- Latency: the valid pulse and all fields appear on the cycle after the edge that samples the message's final byte.
- Fields are registered and hold their values until the next emitted message overwrites them.
- Back-to-back messages are supported with zero idle bytes. The minimum spacing between pulses is 21 bytes (D plus length prefix).
- Reset (asynchronous assert, synchronous release inside the clock domain):
  - All outputs 0, errCnt 0, state HDR, counters 0.
  - Reset mid-message drops the message with no pulse.

## Structure

- Shared package holds:
  - ITCH type constants (0x41, 0x46, 0x44, 0x45) and 0x42.
  - Minimum lengths and field offsets.
  - A parser state enum.
- Single module. No sub-module is warranted; field capture is an offset-indexed case within the BODY state.

## Test plan

- **Single Add:** HDR_BYTES=20. 20 header bytes, then L=0x0024, type 'A', locate 0x0007, ref 0x0000000000001234, 'B', shares 100, price 0x000186A0, lastIn on byte 36.
  - Required: one addValidOut pulse one cycle later, with refNum 0x1234, locate 7, shares 100, price 100000, buySell 1.
- **D then E, same packet:** D with ref 0x55, then E with ref 0x55, shares 40.
  - Required: delValidOut, then execValidOut (sharesOut 40), zero bytes apart.
  - Both pulses occur; priceOut is unchanged.
- **Skipped types:** 'S' (L=12) and 'F' (L=40, 'S' side) between HDR and end.
  - Required: 'S' is skipped with no pulse and no error. 'F' pulses addValidOut with buySell 0.
- **Truncation:** 'A' with lastIn at offset 20.
  - Required: no pulse, errCntOut=1, parser back in HDR.
  - A following packet then parses normally.
- **Short length:** 'D' with L=10.
  - Required: no pulse, errCntOut +1, and the next message parses.
- **Gaps and reset:** random dataInValid gaps give the same results as the gapless case. rstIn asserted mid-BODY clears all outputs asynchronously and no pulse follows.

Source files
------------

// File: rtl/itch_msg_parser_pkg.sv
// Shared constants for the ITCH 5.0 message splitter: message types, minimum lengths,
// field offsets within a message body, and the parser state encoding.
package itch_msg_parser_pkg;

  localparam logic [7:0] TYPE_ADD      = 8'h41;
  localparam logic [7:0] TYPE_ADD_MPID = 8'h46;
  localparam logic [7:0] TYPE_DEL      = 8'h44;
  localparam logic [7:0] TYPE_EXEC     = 8'h45;
  localparam logic [7:0] SIDE_BUY      = 8'h42;

  localparam logic [15:0] MIN_LEN_ADD      = 16'd36;
  localparam logic [15:0] MIN_LEN_ADD_MPID = 16'd40;
  localparam logic [15:0] MIN_LEN_DEL      = 16'd19;
  localparam logic [15:0] MIN_LEN_EXEC     = 16'd31;

  localparam logic [15:0] OFF_LOC_FIRST   = 16'd1;
  localparam logic [15:0] OFF_LOC_LAST    = 16'd2;
  localparam logic [15:0] OFF_REF_FIRST   = 16'd11;
  localparam logic [15:0] OFF_REF_LAST    = 16'd18;
  localparam logic [15:0] OFF_ADD_SIDE    = 16'd19;
  localparam logic [15:0] OFF_ADD_SH_FIRST = 16'd20;
  localparam logic [15:0] OFF_ADD_SH_LAST  = 16'd23;
  localparam logic [15:0] OFF_ADD_PR_FIRST = 16'd32;
  localparam logic [15:0] OFF_ADD_PR_LAST  = 16'd35;
  localparam logic [15:0] OFF_EXEC_SH_FIRST = 16'd19;
  localparam logic [15:0] OFF_EXEC_SH_LAST  = 16'd22;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_BODY
  } parseState_t;

  function automatic logic isAdd(input logic [7:0] msgType);
    return (msgType == TYPE_ADD) || (msgType == TYPE_ADD_MPID);
  endfunction

  function automatic logic isSupported(input logic [7:0] msgType);
    return isAdd(msgType) || (msgType == TYPE_DEL) || (msgType == TYPE_EXEC);
  endfunction

  function automatic logic [15:0] minLen(input logic [7:0] msgType);
    case (msgType)
      TYPE_ADD:      return MIN_LEN_ADD;
      TYPE_ADD_MPID: return MIN_LEN_ADD_MPID;
      TYPE_DEL:      return MIN_LEN_DEL;
      TYPE_EXEC:     return MIN_LEN_EXEC;
      default:       return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_msg_parser_if.sv
// Byte-stream input and decoded-message output bundle of the ITCH message parser.
interface itch_msg_parser_if;
  logic        dataInValid;
  logic [7:0]  dataIn;
  logic        lastIn;
  logic        addValidOut;
  logic        delValidOut;
  logic        execValidOut;
  logic [63:0] refNumOut;
  logic [15:0] locateOut;
  logic [31:0] priceOut;
  logic [31:0] sharesOut;
  logic        buySellOut;
  logic [15:0] errCntOut;

  modport master (
    output dataInValid, dataIn, lastIn,
    input  addValidOut, delValidOut, execValidOut, refNumOut, locateOut,
           priceOut, sharesOut, buySellOut, errCntOut
  );

  modport slave (
    input  dataInValid, dataIn, lastIn,
    output addValidOut, delValidOut, execValidOut, refNumOut, locateOut,
           priceOut, sharesOut, buySellOut, errCntOut
  );
endinterface

// File: rtl/itch_msg_parser.sv
// Splits a MoldUDP64 payload into ITCH 5.0 messages and emits Add/Delete/Executed
// fields with a one-cycle valid pulse; other message types are skipped.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_HDR    | skipping the MoldUDP64 header bytes
// ST_LEN_HI | waiting for the high byte of the message length
// ST_LEN_LO | waiting for the low byte of the message length
// ST_BODY   | consuming message bytes at offset 0..L-1, capturing fields
module itch_msg_parser
  import itch_msg_parser_pkg::*;
#(
  parameter int HDR_BYTES = 20
) (
  input logic           clkIn,
  input logic           rstIn,
  itch_msg_parser_if.slave bus
);

  localparam logic [15:0] HDR_LAST = 16'(HDR_BYTES - 1);

  parseState_t state;
  logic [15:0] hdrCnt;
  logic [15:0] offset;
  logic [15:0] msgLen;
  logic [7:0]  lenHi;
  logic [7:0]  msgType;

  logic [15:0] locSh,  locNxt;
  logic [63:0] refSh,  refNxt;
  logic        bsSh,   bsNxt;
  logic [31:0] shSh,   shNxt;
  logic [31:0] prSh,   prNxt;

  logic [7:0]  curType;
  logic        finalByte;
  logic        typeOk;
  logic        lenOk;

  logic        addValid, delValid, execValid;
  logic [63:0] refNum;
  logic [15:0] locate;
  logic [31:0] price, shares;
  logic        buySell;
  logic [15:0] errCnt;

  // Shadow fields merged with the current byte, so a field ending on the final byte
  // is complete in the same cycle the message is emitted.
  always_comb begin
    curType   = (offset == 16'd0) ? bus.dataIn : msgType;
    locNxt    = locSh;
    refNxt    = refSh;
    bsNxt     = bsSh;
    shNxt     = shSh;
    prNxt     = prSh;
    if (offset >= OFF_LOC_FIRST && offset <= OFF_LOC_LAST)
      locNxt = {locSh[7:0], bus.dataIn};
    if (offset >= OFF_REF_FIRST && offset <= OFF_REF_LAST)
      refNxt = {refSh[55:0], bus.dataIn};
    if (isAdd(curType)) begin
      if (offset == OFF_ADD_SIDE)
        bsNxt = (bus.dataIn == SIDE_BUY);
      if (offset >= OFF_ADD_SH_FIRST && offset <= OFF_ADD_SH_LAST)
        shNxt = {shSh[23:0], bus.dataIn};
      if (offset >= OFF_ADD_PR_FIRST && offset <= OFF_ADD_PR_LAST)
        prNxt = {prSh[23:0], bus.dataIn};
    end else if (curType == TYPE_EXEC) begin
      if (offset >= OFF_EXEC_SH_FIRST && offset <= OFF_EXEC_SH_LAST)
        shNxt = {shSh[23:0], bus.dataIn};
    end
    finalByte = (offset == (msgLen - 16'd1));
    typeOk    = isSupported(curType);
    lenOk     = (msgLen >= minLen(curType));
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state     <= ST_HDR;
      hdrCnt    <= '0;
      offset    <= '0;
      msgLen    <= '0;
      lenHi     <= '0;
      msgType   <= '0;
      locSh     <= '0;
      refSh     <= '0;
      bsSh      <= 1'b0;
      shSh      <= '0;
      prSh      <= '0;
      addValid  <= 1'b0;
      delValid  <= 1'b0;
      execValid <= 1'b0;
      refNum    <= '0;
      locate    <= '0;
      price     <= '0;
      shares    <= '0;
      buySell   <= 1'b0;
      errCnt    <= '0;
    end else begin
      addValid  <= 1'b0;
      delValid  <= 1'b0;
      execValid <= 1'b0;
      if (bus.dataInValid) begin
        case (state)
          ST_HDR: begin
            if (bus.lastIn) begin
              hdrCnt <= '0;
            end else if (hdrCnt == HDR_LAST) begin
              hdrCnt <= '0;
              state  <= ST_LEN_HI;
            end else begin
              hdrCnt <= hdrCnt + 16'd1;
            end
          end
          ST_LEN_HI: begin
            lenHi <= bus.dataIn;
            state <= bus.lastIn ? ST_HDR : ST_LEN_LO;
          end
          ST_LEN_LO: begin
            msgLen <= {lenHi, bus.dataIn};
            offset <= '0;
            if (bus.lastIn)
              state <= ST_HDR;
            else if ({lenHi, bus.dataIn} == 16'd0)
              state <= ST_LEN_HI;
            else
              state <= ST_BODY;
          end
          ST_BODY: begin
            if (offset == 16'd0)
              msgType <= bus.dataIn;
            locSh  <= locNxt;
            refSh  <= refNxt;
            bsSh   <= bsNxt;
            shSh   <= shNxt;
            prSh   <= prNxt;
            offset <= offset + 16'd1;
            if (finalByte) begin
              if (typeOk && lenOk) begin
                refNum <= refNxt;
                locate <= locNxt;
                case (curType)
                  TYPE_ADD, TYPE_ADD_MPID: begin
                    addValid <= 1'b1;
                    shares   <= shNxt;
                    price    <= prNxt;
                    buySell  <= bsNxt;
                  end
                  TYPE_DEL: delValid <= 1'b1;
                  TYPE_EXEC: begin
                    execValid <= 1'b1;
                    shares    <= shNxt;
                  end
                  default: ;
                endcase
              end else if (typeOk && errCnt != 16'hFFFF) begin
                errCnt <= errCnt + 16'd1;
              end
              state <= bus.lastIn ? ST_HDR : ST_LEN_HI;
            end else if (bus.lastIn) begin
              // A type byte alone is not counted as a truncated message.
              if (typeOk && offset != 16'd0 && errCnt != 16'hFFFF)
                errCnt <= errCnt + 16'd1;
              state <= ST_HDR;
            end
          end
          default: state <= ST_HDR;
        endcase
      end
    end
  end

  assign bus.addValidOut  = addValid;
  assign bus.delValidOut  = delValid;
  assign bus.execValidOut = execValid;
  assign bus.refNumOut    = refNum;
  assign bus.locateOut    = locate;
  assign bus.priceOut     = price;
  assign bus.sharesOut    = shares;
  assign bus.buySellOut   = buySell;
  assign bus.errCntOut    = errCnt;

endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed bench for itch_msg_parser: builds MoldUDP64 payloads byte by byte and
// checks pulses, fields and the error counter against hand-computed values.
module tb_itch_msg_parser;

  typedef logic [7:0] byteQ_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  itch_msg_parser_if bus();

  itch_msg_parser #(.HDR_BYTES(20)) dut (
    .clkIn (clk),
    .rstIn (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;
  int addCnt = 0;
  int delCnt = 0;
  int execCnt = 0;
  logic multiHigh = 1'b0;
  logic gapMode = 1'b0;

  always @(negedge clk) begin
    if (bus.addValidOut === 1'b1) addCnt++;
    if (bus.delValidOut === 1'b1) delCnt++;
    if (bus.execValidOut === 1'b1) execCnt++;
    if (int'(bus.addValidOut) + int'(bus.delValidOut) + int'(bus.execValidOut) > 1)
      multiHigh = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    if (gapMode) repeat ($urandom_range(0, 3)) @(posedge clk);
    @(negedge clk);
    bus.dataInValid = 1'b1;
    bus.dataIn      = b;
    bus.lastIn      = last;
    @(posedge clk);
    #1;
    bus.dataInValid = 1'b0;
    bus.lastIn      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendHdr();
    for (int i = 0; i < 20; i++) sendByte(8'(8'hA0 + i), 1'b0);
  endtask

  // Sends the length prefix and body bytes 0..lastAt; lastIn on byte lastAt if useLast.
  task automatic sendMsg(input byteQ_t q, input int lastAt, input logic useLast);
    logic [15:0] len;
    len = 16'(q.size());
    sendByte(len[15:8], 1'b0);
    sendByte(len[7:0], 1'b0);
    for (int i = 0; i <= lastAt; i++) sendByte(q[i], useLast && (i == lastAt));
  endtask

  function automatic byteQ_t mkMsg(input logic [7:0] t, input int len, input logic [15:0] loc,
                                   input logic [63:0] refN, input logic [7:0] side,
                                   input logic [31:0] sh, input logic [31:0] pr);
    byteQ_t q;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'h5A;
      if (i == 0) b = t;
      else if (i <= 2) b = loc[8*(2-i) +: 8];
      else if (i >= 11 && i <= 18) b = refN[8*(18-i) +: 8];
      else if (t == 8'h41 || t == 8'h46) begin
        if (i == 19) b = side;
        else if (i >= 20 && i <= 23) b = sh[8*(23-i) +: 8];
        else if (i >= 32 && i <= 35) b = pr[8*(35-i) +: 8];
      end else if (t == 8'h45 && i >= 19 && i <= 22) b = sh[8*(22-i) +: 8];
      q.push_back(b);
    end
    return q;
  endfunction

  task automatic packetAddThenDelExec(input string pfx);
    byteQ_t q;
    sendHdr();
    q = mkMsg(8'h41, 36, 16'h0007, 64'h1234, 8'h42, 32'd100, 32'h000186A0);
    sendMsg(q, 35, 1'b1);
    chk({pfx, "add_valid"}, 64'(bus.addValidOut), 64'd1);
    chk({pfx, "add_ref"}, bus.refNumOut, 64'h1234);
    chk({pfx, "add_loc"}, 64'(bus.locateOut), 64'd7);
    chk({pfx, "add_shares"}, 64'(bus.sharesOut), 64'd100);
    chk({pfx, "add_price"}, 64'(bus.priceOut), 64'd100000);
    chk({pfx, "add_buysell"}, 64'(bus.buySellOut), 64'd1);
    idle(1);
    chk({pfx, "add_pulse_width"}, 64'(bus.addValidOut), 64'd0);
    sendHdr();
    q = mkMsg(8'h44, 19, 16'h0003, 64'h55, 8'h00, 32'd0, 32'd0);
    sendMsg(q, 18, 1'b0);
    chk({pfx, "del_valid"}, 64'(bus.delValidOut), 64'd1);
    chk({pfx, "del_ref"}, bus.refNumOut, 64'h55);
    chk({pfx, "del_loc"}, 64'(bus.locateOut), 64'd3);
    q = mkMsg(8'h45, 31, 16'h0003, 64'h55, 8'h00, 32'd40, 32'd0);
    sendMsg(q, 30, 1'b1);
    chk({pfx, "exec_valid"}, 64'(bus.execValidOut), 64'd1);
    chk({pfx, "exec_shares"}, 64'(bus.sharesOut), 64'd40);
    chk({pfx, "exec_ref"}, bus.refNumOut, 64'h55);
    chk({pfx, "exec_price_held"}, 64'(bus.priceOut), 64'h000186A0);
    chk({pfx, "exec_buysell_held"}, 64'(bus.buySellOut), 64'd1);
    idle(2);
  endtask

  initial begin
    byteQ_t q;
    int addBase;
    int delBase;
    bus.dataInValid = 1'b0;
    bus.dataIn      = 8'h00;
    bus.lastIn      = 1'b0;

    idle(3);
    chk("rst_add_valid", 64'(bus.addValidOut), 64'd0);
    chk("rst_ref", bus.refNumOut, 64'd0);
    chk("rst_price", 64'(bus.priceOut), 64'd0);
    chk("rst_errcnt", 64'(bus.errCntOut), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    packetAddThenDelExec("nogap_");
    chk("counts_add", 64'(addCnt), 64'd1);
    chk("counts_del", 64'(delCnt), 64'd1);
    chk("counts_exec", 64'(execCnt), 64'd1);

    // 'S' system event skipped, then an MPID add on the sell side
    sendHdr();
    q = mkMsg(8'h53, 12, 16'h0000, 64'h0, 8'h00, 32'd0, 32'd0);
    sendMsg(q, 11, 1'b0);
    q = mkMsg(8'h46, 40, 16'h0009, 64'hABCDEF0123456789, 8'h53, 32'd500, 32'h00112233);
    sendMsg(q, 39, 1'b1);
    chk("f_valid", 64'(bus.addValidOut), 64'd1);
    chk("f_buysell", 64'(bus.buySellOut), 64'd0);
    chk("f_ref", bus.refNumOut, 64'hABCDEF0123456789);
    chk("f_shares", 64'(bus.sharesOut), 64'd500);
    chk("f_price", 64'(bus.priceOut), 64'h00112233);
    chk("f_loc", 64'(bus.locateOut), 64'd9);
    chk("s_no_err", 64'(bus.errCntOut), 64'd0);
    idle(2);
    chk("s_f_addcnt", 64'(addCnt), 64'd2);

    // Truncated Add, then a fresh packet must parse from its header
    sendHdr();
    q = mkMsg(8'h41, 36, 16'h0001, 64'h999, 8'h42, 32'd1, 32'd1);
    sendMsg(q, 20, 1'b1);
    idle(2);
    chk("trunc_errcnt", 64'(bus.errCntOut), 64'd1);
    chk("trunc_no_pulse", 64'(addCnt), 64'd2);
    chk("trunc_ref_held", bus.refNumOut, 64'hABCDEF0123456789);
    sendHdr();
    q = mkMsg(8'h44, 19, 16'h0004, 64'h77, 8'h00, 32'd0, 32'd0);
    sendMsg(q, 18, 1'b1);
    chk("after_trunc_del", 64'(bus.delValidOut), 64'd1);
    chk("after_trunc_ref", bus.refNumOut, 64'h77);

    // Short Delete, then Exec, then an oversized Add
    sendHdr();
    delBase = delCnt;
    q = mkMsg(8'h44, 10, 16'h0004, 64'h0, 8'h00, 32'd0, 32'd0);
    sendMsg(q, 9, 1'b0);
    q = mkMsg(8'h45, 31, 16'h0005, 64'h99, 8'h00, 32'd7, 32'd0);
    sendMsg(q, 30, 1'b0);
    chk("short_next_exec", 64'(bus.execValidOut), 64'd1);
    chk("short_next_shares", 64'(bus.sharesOut), 64'd7);
    chk("short_errcnt", 64'(bus.errCntOut), 64'd2);
    chk("short_no_del", 64'(delCnt), 64'(delBase));
    addBase = addCnt;
    q = mkMsg(8'h41, 38, 16'h0006, 64'h4242, 8'h53, 32'd9, 32'd12345);
    sendMsg(q, 36, 1'b0);
    chk("long_no_early_pulse", 64'(addCnt), 64'(addBase));
    sendByte(q[37], 1'b1);
    chk("long_valid", 64'(bus.addValidOut), 64'd1);
    chk("long_price", 64'(bus.priceOut), 64'd12345);
    idle(2);

    gapMode = 1'b1;
    addBase = addCnt;
    packetAddThenDelExec("gap_");
    chk("gap_addcnt", 64'(addCnt), 64'(addBase + 1));
    gapMode = 1'b0;

    // Reset mid-body clears outputs asynchronously and drops the message
    sendHdr();
    addBase = addCnt;
    q = mkMsg(8'h41, 36, 16'h0002, 64'h31, 8'h42, 32'd3, 32'd4);
    sendMsg(q, 9, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ref", bus.refNumOut, 64'd0);
    chk("arst_price", 64'(bus.priceOut), 64'd0);
    chk("arst_errcnt", 64'(bus.errCntOut), 64'd0);
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 10; i < 36; i++) sendByte(q[i], i == 35);
    idle(2);
    chk("arst_no_pulse", 64'(addCnt), 64'(addBase));
    sendHdr();
    q = mkMsg(8'h41, 36, 16'h0002, 64'h31, 8'h42, 32'd3, 32'd4);
    sendMsg(q, 35, 1'b1);
    chk("post_rst_add", 64'(bus.addValidOut), 64'd1);
    chk("post_rst_ref", bus.refNumOut, 64'h31);
    idle(2);

    chk("one_valid_at_a_time", 64'(multiHigh), 64'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
